mem_bus_responder: RTL and testbench

//  Lower-level memory on the common snoop bus: the responder end of the caches' BusRd/BusRdX/Mem_wr protocol.

---
 rtl/mesi_mem_pkg.sv | 32 +++
 rtl/mem_word_store.sv | 38 +++
 rtl/mem_bus_responder.sv | 132 +++++++++++++
 tb/tb_mem_bus_responder.sv | 230 +++++++++++++++++++++++
 4 files changed

// File: rtl/mesi_mem_pkg.sv
// Shared types and helpers for the snoop-bus memory responder: FSM states,
// latency limits and the pattern returned by words never written since reset.
package mesi_mem_pkg;

    typedef enum logic [2:0] {
        IDLE,
        RD_WAIT,
        RD_REQ,
        RD_DRIVE,
        RD_HOLD,
        WR_WAIT,
        WR_DONE
    } mem_state_t;

    localparam int unsigned CNT_W     = 4;
    localparam int unsigned LAT_MIN   = 1;
    localparam int unsigned LAT_MAX   = 15;
    localparam int unsigned PATTERN_W = 64;

    // Keeps a latency inside what the 4-bit counter can reach.
    function automatic int unsigned clamp_latency(input int unsigned lat);
        if (lat < LAT_MIN) return LAT_MIN;
        if (lat > LAT_MAX) return LAT_MAX;
        return lat;
    endfunction

    // An unwritten word reads back as its own zero-extended index.
    function automatic logic [PATTERN_W-1:0] default_pattern(input logic [PATTERN_W-1:0] idx);
        return idx;
    endfunction

endpackage

// File: rtl/mem_word_store.sv
// Backing store for the responder: word array plus a valid bitmap that is
// cleared by reset so unwritten words fall back to the default pattern.
module mem_word_store #(
    parameter int DATA_W = 32,
    parameter int DEPTH  = 256,
    parameter int IDX_W  = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              we,
    input  logic [IDX_W-1:0]  w_idx,
    input  logic [DATA_W-1:0] w_data,
    input  logic [IDX_W-1:0]  r_idx,
    output logic [DATA_W-1:0] r_data
);
    import mesi_mem_pkg::*;

    logic [DATA_W-1:0] words [DEPTH];
    logic [DEPTH-1:0]  valid;

    always_ff @(posedge clk) begin
        if (we) begin
            words[w_idx] <= w_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid <= '0;
        end else if (we) begin
            valid[w_idx] <= 1'b1;
        end
    end

    assign r_data = valid[r_idx] ? words[r_idx]
                                 : DATA_W'(default_pattern(PATTERN_W'(r_idx)));

endmodule

// File: rtl/mem_bus_responder.sv
// Memory end of the snoop bus: serves BusRd/BusRdX after a fixed latency via
// the data-bus arbiter, absorbs Mem_wr write-backs, and honours read aborts.
module mem_bus_responder #(
    parameter int ADDRESSSIZE   = 32,
    parameter int MEM_DEPTH     = 256,
    parameter int READ_LATENCY  = 4,
    parameter int WRITE_LATENCY = 2
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   BusRd,
    input  logic                   BusRdX,
    input  logic [ADDRESSSIZE-1:0] Address_Com,
    input  logic                   Mem_wr,
    input  logic                   Mem_oprn_abort,
    input  logic                   Mem_snoop_gnt,
    output logic                   Mem_snoop_req,
    output logic                   Mem_write_done,
    inout  wire  [ADDRESSSIZE-1:0] Data_Bus_Com,
    inout  wire                    Data_in_Bus
);
    import mesi_mem_pkg::*;

    localparam int IDX_W = $clog2(MEM_DEPTH);
    localparam logic [CNT_W-1:0] RD_LAT = CNT_W'(clamp_latency(READ_LATENCY));
    localparam logic [CNT_W-1:0] WR_LAT = CNT_W'(clamp_latency(WRITE_LATENCY));

    mem_state_t             state, state_next;
    logic [CNT_W-1:0]       cnt, cnt_next;
    logic [IDX_W-1:0]       rd_idx;
    logic                   rd_latch;
    logic                   mem_we;
    logic                   rd_any;
    logic [ADDRESSSIZE-1:0] rd_data;
    logic                   unused_addr_hi;

    assign rd_any         = BusRd | BusRdX;
    assign unused_addr_hi = ^Address_Com[ADDRESSSIZE-1:IDX_W];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            cnt   <= '0;
        end else begin
            state <= state_next;
            cnt   <= cnt_next;
        end
    end

    // Index is captured once at accept; later address changes must not leak in.
    always_ff @(posedge clk) begin
        if (rd_latch) begin
            rd_idx <= Address_Com[IDX_W-1:0];
        end
    end

    always_comb begin
        state_next = state;
        cnt_next   = cnt;
        rd_latch   = 1'b0;
        mem_we     = 1'b0;
        case (state)
            IDLE: begin
                if (Mem_wr) begin
                    mem_we     = 1'b1;
                    cnt_next   = CNT_W'(1);
                    state_next = WR_WAIT;
                end else if (rd_any) begin
                    rd_latch   = 1'b1;
                    cnt_next   = CNT_W'(1);
                    state_next = RD_WAIT;
                end
            end
            RD_WAIT: begin
                if (Mem_oprn_abort || !rd_any) begin
                    state_next = IDLE;
                end else if (cnt == RD_LAT) begin
                    state_next = RD_REQ;
                end else begin
                    cnt_next = cnt + CNT_W'(1);
                end
            end
            RD_REQ: begin
                // Abort outranks a grant arriving on the same edge.
                if (Mem_oprn_abort || !rd_any) begin
                    state_next = IDLE;
                end else if (Mem_snoop_gnt) begin
                    state_next = RD_DRIVE;
                end
            end
            RD_DRIVE: state_next = RD_HOLD;
            RD_HOLD: begin
                if (!rd_any) begin
                    state_next = IDLE;
                end
            end
            WR_WAIT: begin
                if (cnt == WR_LAT) begin
                    state_next = WR_DONE;
                end else begin
                    cnt_next = cnt + CNT_W'(1);
                end
            end
            WR_DONE: begin
                if (!Mem_wr) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    mem_word_store #(
        .DATA_W (ADDRESSSIZE),
        .DEPTH  (MEM_DEPTH),
        .IDX_W  (IDX_W)
    ) u_store (
        .clk    (clk),
        .rst_n  (rst_n),
        .we     (mem_we),
        .w_idx  (Address_Com[IDX_W-1:0]),
        .w_data (Data_Bus_Com),
        .r_idx  (rd_idx),
        .r_data (rd_data)
    );

    assign Mem_snoop_req  = (state == RD_REQ);
    assign Mem_write_done = (state == WR_DONE);
    assign Data_Bus_Com   = (state == RD_DRIVE) ? rd_data : {ADDRESSSIZE{1'bz}};
    assign Data_in_Bus    = (state == RD_DRIVE) ? 1'b1 : 1'bz;

endmodule

// File: tb/tb_mem_bus_responder.sv
// Directed bench for mem_bus_responder: read data is queued when the request
// is issued and popped when the responder drives the bus.
module tb_mem_bus_responder;

    localparam int AW     = 32;
    localparam int RD_LAT = 4;
    localparam int WR_LAT = 2;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          busrd, busrdx, mem_wr, abort, gnt;
    logic [AW-1:0] addr;
    logic          drv_en;
    logic [AW-1:0] drv_val;
    logic          req, done;
    wire  [AW-1:0] data_bus;
    wire           data_in_bus;

    int            n_assert = 0;
    int            n_fail   = 0;
    logic [AW-1:0] sb_q[$];

    assign data_bus = drv_en ? drv_val : {AW{1'bz}};
    pulldown pd_din (data_in_bus);

    always #5 clk = ~clk;

    mem_bus_responder #(
        .ADDRESSSIZE   (AW),
        .MEM_DEPTH     (256),
        .READ_LATENCY  (RD_LAT),
        .WRITE_LATENCY (WR_LAT)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .BusRd          (busrd),
        .BusRdX         (busrdx),
        .Address_Com    (addr),
        .Mem_wr         (mem_wr),
        .Mem_oprn_abort (abort),
        .Mem_snoop_gnt  (gnt),
        .Mem_snoop_req  (req),
        .Mem_write_done (done),
        .Data_Bus_Com   (data_bus),
        .Data_in_Bus    (data_in_bus)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic do_read(input logic [AW-1:0] a, input bit rdx, input int gnt_delay,
                           input logic [AW-1:0] exp);
        int n;
        busrd  = !rdx;
        busrdx = rdx;
        addr   = a;
        tick();
        addr = ~a;
        n = 1;
        while (!req && n < 40) begin
            tick();
            n++;
        end
        check("rd_latency", 32'(n), 32'(RD_LAT + 1));
        sb_q.push_back(exp);
        if (gnt_delay == 0) begin
            tick();
        end else begin
            for (int k = 1; k <= gnt_delay; k++) begin
                check("req_held", 32'(req), 32'd1);
                check("no_early_drive", 32'(data_in_bus), 32'd0);
                if (k == gnt_delay) gnt = 1'b1;
                tick();
            end
        end
        check("rd_drive", 32'(data_in_bus), 32'd1);
        check("req_drop", 32'(req), 32'd0);
        if (data_in_bus === 1'b1 && sb_q.size() > 0) begin
            check("rd_data", data_bus, sb_q.pop_front());
        end
        tick();
        check("rd_one_cycle", 32'(data_in_bus), 32'd0);
        busrd  = 1'b0;
        busrdx = 1'b0;
        tick();
        check("rd_no_repeat", 32'(data_in_bus), 32'd0);
        check("rd_idle_req", 32'(req), 32'd0);
    endtask

    task automatic do_write(input logic [AW-1:0] a, input logic [AW-1:0] d);
        int n;
        mem_wr  = 1'b1;
        addr    = a;
        drv_en  = 1'b1;
        drv_val = d;
        tick();
        drv_en = 1'b0;
        n = 1;
        while (!done && n < 40) begin
            tick();
            n++;
        end
        check("wr_latency", 32'(n), 32'(WR_LAT + 1));
        repeat (2) begin
            tick();
            check("wr_done_held", 32'(done), 32'd1);
        end
        mem_wr = 1'b0;
        tick();
        check("wr_done_drop", 32'(done), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        rst_n   = 1'b0;
        busrd   = 1'b0;
        busrdx  = 1'b0;
        mem_wr  = 1'b0;
        abort   = 1'b0;
        gnt     = 1'b1;
        addr    = '0;
        drv_en  = 1'b0;
        drv_val = '0;
        repeat (3) tick();
        check("rst_req", 32'(req), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_din", 32'(data_in_bus), 32'd0);
        rst_n = 1'b1;
        tick();

        // 1: cold read returns the default pattern
        do_read(32'h0000_0012, 1'b0, 0, 32'h0000_0012);

        // 2: write-back, then an aliased BusRdX sees the new data
        do_write(32'h0000_0012, 32'hDEAD_BEEF);
        do_read(32'h0000_0112, 1'b1, 0, 32'hDEAD_BEEF);

        // 3: abort in the third wait cycle; FSM must be idle right after
        busrd = 1'b1;
        addr  = 32'h0000_0040;
        for (int c = 0; c < 3; c++) begin
            tick();
            check("abort_no_req", 32'(req), 32'd0);
        end
        abort = 1'b1;
        tick();
        check("abort_req", 32'(req), 32'd0);
        check("abort_din", 32'(data_in_bus), 32'd0);
        abort = 1'b0;
        busrd = 1'b0;
        do_read(32'h0000_0041, 1'b0, 0, 32'h0000_0041);

        // 4: grant and abort together in RD_REQ, then a late grant
        gnt   = 1'b0;
        busrd = 1'b1;
        addr  = 32'h0000_0033;
        tick();
        n = 1;
        while (!req && n < 40) begin
            tick();
            n++;
        end
        check("coll_latency", 32'(n), 32'(RD_LAT + 1));
        gnt   = 1'b1;
        abort = 1'b1;
        tick();
        check("coll_req", 32'(req), 32'd0);
        check("coll_din", 32'(data_in_bus), 32'd0);
        abort = 1'b0;
        gnt   = 1'b0;
        busrd = 1'b0;
        tick();
        check("coll_after", 32'(data_in_bus), 32'd0);
        do_read(32'h0000_0077, 1'b0, 5, 32'h0000_0077);

        // 5: write and read on the same edge; the read returns the new word
        gnt   = 1'b1;
        busrd = 1'b1;
        do_write(32'h0000_0012, 32'h5A5A_5A5A);
        do_read(32'h0000_0012, 1'b0, 0, 32'h5A5A_5A5A);

        // 6: reset during RD_REQ drops everything and forgets the write
        do_write(32'h0000_0012, 32'h0BAD_F00D);
        gnt   = 1'b0;
        busrd = 1'b1;
        addr  = 32'h0000_0012;
        tick();
        n = 1;
        while (!req && n < 40) begin
            tick();
            n++;
        end
        check("rst6_latency", 32'(n), 32'(RD_LAT + 1));
        #2;
        rst_n = 1'b0;
        #1;
        check("rst6_req", 32'(req), 32'd0);
        check("rst6_din", 32'(data_in_bus), 32'd0);
        check("rst6_done", 32'(done), 32'd0);
        busrd = 1'b0;
        gnt   = 1'b1;
        tick();
        tick();
        #2;
        rst_n = 1'b1;
        tick();
        do_read(32'h0000_0012, 1'b0, 0, 32'h0000_0012);

        check("sb_empty", 32'(sb_q.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
